// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: adds or subtracts two WORDS*XLEN-bit operands by
// reusing a single XLEN-bit ripple adder (Adder) for WORDS cycles,
// least-significant word first, with the carry registered between cycles.
//
// Handshake: start is accepted only when the block is not in RUN (IDLE or
// DONE). An accepted start latches op_a/op_b/sub. busy is high for exactly
// WORDS cycles. done then pulses for one cycle with result/carry_out valid.
// result/carry_out hold until the next accepted start.
//
// Optional build macro OVERFLOW_EN adds the signed overflow output.
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).

// XLEN-bit ripple-carry adder; out[XLEN] is the carry out.
module Adder #(
  parameter int XLEN = 8
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN:0]   out
);
  logic [XLEN:0]   c;
  logic [XLEN-1:0] s;

  // Bit-serial carry chain evaluated combinationally.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < XLEN; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    out = {c[XLEN], s};
  end
endmodule

module multiword_add_ctrl #(
  parameter int XLEN  = 8,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [WORDS*XLEN-1:0] op_a,
  input  logic [WORDS*XLEN-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [WORDS*XLEN-1:0] result,
  output logic                  carry_out,
`ifdef OVERFLOW_EN
  output logic                  overflow,
`endif
  output logic [1:0]            dbg_state
);
  localparam int W    = WORDS * XLEN;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [IDXW-1:0] idx;
  logic            carry_q;
  logic            sub_q;
  logic [W-1:0]    a_q, b_q;
  logic            accept;
  logic            last_word;
  logic [XLEN-1:0] a_word, b_word, b_eff;
  logic [XLEN:0]   add_out;

  // Word selection for the shared adder; B is inverted for subtraction.
  always_comb begin
    a_word    = a_q[idx*XLEN +: XLEN];
    b_word    = b_q[idx*XLEN +: XLEN];
    b_eff     = sub_q ? ~b_word : b_word;
    last_word = (idx == LAST_IDX);
  end

  Adder #(.XLEN(XLEN)) u_adder (
    .a   (a_word),
    .b   (b_eff),
    .cin (carry_q),
    .out (add_out)
  );

  // Next-state logic and handshake outputs.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_word) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, operand latches and per-word result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_q       <= op_a;
        b_q       <= op_b;
        sub_q     <= sub;
        carry_q   <= sub;
        idx       <= '0;
        result    <= '0;
        carry_out <= 1'b0;
`ifdef OVERFLOW_EN
        overflow  <= 1'b0;
`endif
      end else if (state == RUN) begin
        result[idx*XLEN +: XLEN] <= add_out[XLEN-1:0];
        carry_q                  <= add_out[XLEN];
        if (last_word) begin
          carry_out <= add_out[XLEN];
`ifdef OVERFLOW_EN
          overflow  <= (a_word[XLEN-1] == b_eff[XLEN-1]) &&
                       (add_out[XLEN-1] != a_word[XLEN-1]);
`endif
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule
